// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronizes and debounces the rows,
// then decodes each accepted press into one-cycle digit/operator/equals/clear pulses.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       digit_valid,
    output logic [3:0] digit_val,
    output logic [1:0] op_val,
    output logic       eq_pulse,
    output logic       clr_pulse
);

    localparam int MAX_COUNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    state_t        state;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [3:0]    pat;
    logic [1:0]    col_idx;
    logic [CW-1:0] cnt;

    logic       single;
    logic [1:0] row_idx;
    logic [3:0] dec_code;
    logic       dec_mapped;
    logic       dec_digit;
    logic [3:0] dec_dval;
    logic [1:0] dec_op;
    logic       dec_eq;
    logic       dec_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= row_n;
            rows_s <= rows_m;
        end
    end

    assign col_n = ~(4'b0001 << col_idx);

    // A captured pattern with exactly one low row names a single key in the held column.
    always_comb begin
        single     = 1'b0;
        row_idx    = 2'd0;
        dec_mapped = 1'b1;
        dec_digit  = 1'b0;
        dec_dval   = 4'd0;
        dec_op     = 2'b00;
        dec_eq     = 1'b0;
        dec_clr    = 1'b0;
        case (pat)
            4'b1110: begin single = 1'b1; row_idx = 2'd0; end
            4'b1101: begin single = 1'b1; row_idx = 2'd1; end
            4'b1011: begin single = 1'b1; row_idx = 2'd2; end
            4'b0111: begin single = 1'b1; row_idx = 2'd3; end
            default: ;
        endcase
        dec_code = {row_idx, col_idx};
        case (dec_code)
            4'd0:  begin dec_digit = 1'b1; dec_dval = 4'd1; end
            4'd1:  begin dec_digit = 1'b1; dec_dval = 4'd2; end
            4'd2:  begin dec_digit = 1'b1; dec_dval = 4'd3; end
            4'd3:  dec_op = 2'b01;
            4'd4:  begin dec_digit = 1'b1; dec_dval = 4'd4; end
            4'd5:  begin dec_digit = 1'b1; dec_dval = 4'd5; end
            4'd6:  begin dec_digit = 1'b1; dec_dval = 4'd6; end
            4'd7:  dec_op = 2'b10;
            4'd8:  begin dec_digit = 1'b1; dec_dval = 4'd7; end
            4'd9:  begin dec_digit = 1'b1; dec_dval = 4'd8; end
            4'd10: begin dec_digit = 1'b1; dec_dval = 4'd9; end
            4'd11: dec_clr = 1'b1;
            4'd13: begin dec_digit = 1'b1; dec_dval = 4'd0; end
            4'd15: dec_eq = 1'b1;
            default: dec_mapped = 1'b0;
        endcase
    end

    // Every state leaves at its terminal count, so the shared counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            pat         <= 4'hF;
            col_idx     <= 2'd0;
            cnt         <= '0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            digit_valid <= 1'b0;
            digit_val   <= 4'd0;
            op_val      <= 2'b00;
            eq_pulse    <= 1'b0;
            clr_pulse   <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            digit_valid <= 1'b0;
            op_val      <= 2'b00;
            eq_pulse    <= 1'b0;
            clr_pulse   <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (rows_s != 4'hF) begin
                            pat   <= rows_s;
                            state <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != pat) begin
                        cnt   <= '0;
                        state <= SCAN;
                    end else if (cnt == DB_LAST) begin
                        cnt <= '0;
                        if (single) begin
                            state <= EMIT;
                            if (dec_mapped) begin
                                key_valid   <= 1'b1;
                                key_code    <= dec_code;
                                digit_valid <= dec_digit;
                                op_val      <= dec_op;
                                eq_pulse    <= dec_eq;
                                clr_pulse   <= dec_clr;
                                if (dec_digit) begin
                                    digit_val <= dec_dval;
                                end
                            end
                        end else begin
                            state <= WAIT_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    cnt   <= '0;
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (rows_s != 4'hF) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        cnt     <= '0;
                        col_idx <= col_idx + 2'd1;
                        state   <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives the rows from the
// driven column, expected key events are queued at press time and matched on each pulse.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       digit_valid;
    logic [3:0] digit_val;
    logic [1:0] op_val;
    logic       eq_pulse;
    logic       clr_pulse;

    logic [15:0] keys;
    logic [13:0] exp_q[$];
    logic [3:0]  last_code;
    logic [3:0]  last_dval;
    int          total;
    int          bad;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_valid(key_valid), .key_code(key_code),
        .digit_valid(digit_valid), .digit_val(digit_val),
        .op_val(op_val), .eq_pulse(eq_pulse), .clr_pulse(clr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (keys[i*4+j] && !col_n[j]) row_n[i] = 1'b0;
    end

    // Expected event vector: {key_valid, key_code, digit_valid, digit_val, op_val, eq, clr}.
    task automatic expect_key(input int code);
        logic       dig;
        logic [3:0] dv;
        logic [1:0] op;
        logic       eq;
        logic       clr;
        dig = 1'b0; dv = last_dval; op = 2'b00; eq = 1'b0; clr = 1'b0;
        case (code)
            0: begin dig = 1'b1; dv = 4'd1; end
            1: begin dig = 1'b1; dv = 4'd2; end
            2: begin dig = 1'b1; dv = 4'd3; end
            3: op = 2'b01;
            4: begin dig = 1'b1; dv = 4'd4; end
            5: begin dig = 1'b1; dv = 4'd5; end
            6: begin dig = 1'b1; dv = 4'd6; end
            7: op = 2'b10;
            8: begin dig = 1'b1; dv = 4'd7; end
            9: begin dig = 1'b1; dv = 4'd8; end
            10: begin dig = 1'b1; dv = 4'd9; end
            11: clr = 1'b1;
            13: begin dig = 1'b1; dv = 4'd0; end
            15: eq = 1'b1;
            default: ;
        endcase
        last_code = 4'(code);
        last_dval = dv;
        exp_q.push_back({1'b1, last_code, dig, dv, op, eq, clr});
    endtask

    task automatic press(input int code, input int hold);
        keys[code] = 1'b1;
        repeat (hold) @(negedge clk);
        keys[code] = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic monitor_loop();
        logic [13:0] obs;
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && (key_valid || digit_valid || op_val != 2'b00 || eq_pulse || clr_pulse)) begin
                obs = {key_valid, key_code, digit_valid, digit_val, op_val, eq_pulse, clr_pulse};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_event at %0t: got %h, required no event", $time, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        bad++;
                        $display("[TB] FAIL event at %0t: got %h, required %h", $time, obs, e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({col_n, key_valid, digit_valid, op_val, eq_pulse, clr_pulse, key_code, digit_val} !== {4'b1110, 14'd0}) begin
            bad++;
            $display("[TB] FAIL reset_values: got col=%b kv=%b dv=%b op=%b eq=%b clr=%b code=%0d val=%0d, required col=1110 rest 0",
                     col_n, key_valid, digit_valid, op_val, eq_pulse, clr_pulse, key_code, digit_val);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            total++;
            if (col_n !== ~(4'b0001 << ((k / 4) % 4))) begin
                bad++;
                $display("[TB] FAIL scan_col k=%0d: got %b, required %b", k, col_n, ~(4'b0001 << ((k / 4) % 4)));
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (col_n !== 4'b1110 || op_val !== 2'b00 || key_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midscan_reset: got col=%b op=%b kv=%b, required 1110 00 0", col_n, op_val, key_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_digits();
        expect_key(5);
        press(5, 200);
        expect_key(13);
        press(13, 200);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL digits_drained: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_operators();
        expect_key(3);
        press(3, 100);
        expect_key(7);
        press(7, 100);
        expect_key(15);
        press(15, 100);
        expect_key(11);
        press(11, 100);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL ops_drained: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 10; t++) begin
            keys[8] = ~keys[8];
            repeat (3) @(negedge clk);
        end
        expect_key(8);
        keys[8] = 1'b1;
        repeat (100) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            keys[8] = 1'b0;
            repeat (4) @(negedge clk);
            keys[8] = 1'b1;
            repeat (4) @(negedge clk);
        end
        keys[8] = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL bounce_first: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        expect_key(8);
        press(8, 100);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL bounce_second: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_multikey();
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        repeat (100) @(negedge clk);
        keys[0] = 1'b0;
        keys[4] = 1'b0;
        repeat (40) @(negedge clk);
        expect_key(4);
        press(4, 100);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL multikey_single: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_unmapped();
        int waited;
        keys[12] = 1'b1;
        repeat (100) @(negedge clk);
        total++;
        if (col_n !== 4'b1110) begin
            bad++;
            $display("[TB] FAIL unmapped_hold_col: got %b, required 1110", col_n);
        end
        keys[12] = 1'b0;
        waited = 0;
        while (col_n === 4'b1110 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (col_n !== 4'b1101) begin
            bad++;
            $display("[TB] FAIL unmapped_resume: got %b after %0d cycles, required 1101", col_n, waited);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        expect_key(5);
        exp_q.delete();
        keys[5] = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        keys[5] = 1'b0;
        #1;
        total++;
        if (col_n !== 4'b1110 || key_code !== 4'd0) begin
            bad++;
            $display("[TB] FAIL abort_reset: got col=%b code=%0d, required 1110 0", col_n, key_code);
        end
        last_code = 4'd0;
        last_dval = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        expect_key(1);
        press(1, 100);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL abort_next: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        keys = 16'd0;
        last_code = 4'd0;
        last_dval = 4'd0;
        rst_n = 1'b0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_digits();
        test_operators();
        test_bounce();
        test_multikey();
        test_unmapped();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronizes and debounces the row inputs, and decodes each accepted press into one-cycle pulses.
- Producer side of the calculator key path: its op_val output follows the operator encoding used by the operator register (01 = "+", 10 = "-", 00 = no event).
- Its digit, equals and clear pulses feed the operand entry and control logic.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven before its rows are sampled (settle time); minimum 2.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press and to accept a release; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row_n  input  4  keypad rows, active-low, asynchronous to clk; bit i = row i
- col_n  output  4  column drive, active-low one-hot; bit j = column j
- key_valid  output  1  one-cycle pulse when any mapped key is accepted
- key_code  output  4  row*4+col of the last accepted key; held between pulses
- digit_valid  output  1  one-cycle pulse for a digit key
- digit_val  output  4  digit value 0-9; valid with digit_valid, held otherwise
- op_val  output  2  01 for "+", 10 for "-" during the pulse cycle; 00 at all other times
- eq_pulse  output  1  one-cycle pulse for "="
- clr_pulse  output  1  one-cycle pulse for clear

Behaviour:
- Reset is asynchronous: col_n=1110, all pulses 0, op_val=00, key_code=0, digit_val=0, col_idx=0, counters 0, sync flops 1111, state SCAN.
- Key map, rows top to bottom:
  - row0: 1 2 3 +
  - row1: 4 5 6 -
  - row2: 7 8 9 C(clear)
  - row3: unmapped, 0, unmapped, =
- Unmapped keys (codes 12 and 14) complete debounce and release but emit no pulse.
- row_n passes through a 2-flop synchronizer. rows_s is the synchronized value, and all decisions use rows_s.
- FSM states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
- SCAN:
  - col_n = ~(1<<col_idx); the dwell counter runs 0..SCAN_DIV-1.
  - At dwell = SCAN_DIV-1:
    - If rows_s != 1111: capture rows_s into pat, clear the counter, go to DEBOUNCE. col_idx is held.
    - Otherwise: col_idx increments (3 wraps to 0) and dwell clears.
- DEBOUNCE: column held; the counter increments each cycle while rows_s == pat.
  - If rows_s != pat on any cycle: return to SCAN with the same col_idx and dwell 0. No output.
  - When the counter reaches DEBOUNCE_CYCLES-1 with rows_s == pat:
    - If pat has exactly one zero bit: go to EMIT.
    - If pat has two or more zero bits (multiple keys in one column): go to WAIT_RELEASE with no output.
- EMIT: lasts exactly one cycle. On entry, the registered outputs update with the pulse(s) for the decoded key. Then go to WAIT_RELEASE.
  - Pulse set per key class:
    - Any mapped key: key_valid and key_code.
    - Digit key: digit_valid and digit_val.
    - "+" or "-": op_val.
    - "=": eq_pulse.
    - C: clr_pulse.
  - Pulses deassert, and op_val returns to 00, on the next edge.
- WAIT_RELEASE: column held.
  - The counter clears on any cycle with rows_s != 1111 and increments otherwise.
  - At DEBOUNCE_CYCLES-1 consecutive cycles of 1111: go to SCAN with col_idx advanced by one (wrap) and dwell 0.
  - A held key therefore produces exactly one event: no auto-repeat.
- Latency from a stable press: at most one synchronizer delay (2 cycles), plus a wait of up to 4*SCAN_DIV for the scan to reach the column, plus DEBOUNCE_CYCLES, plus 1 cycle to the pulse.
- At most one pulse group per accepted key. op_val is never 11.
- Keys in other columns pressed during DEBOUNCE, EMIT or WAIT_RELEASE are not seen, because only the held column is driven.
- Reset asserted mid-operation aborts immediately to the reset values. No pulse is emitted after rst_n rises until a complete press is accepted again.
- Counter widths are $clog2 of the larger of the parameters. Counters never wrap, because every state leaves at its terminal count.

Test Plan:
Bench parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_CYCLES=8. The keypad model ties row i low when a key at (i, driven column) is pressed.
- Reset: assert rst_n=0 mid-scan -> col_n=1110 immediately, all pulses 0, op_val=00. After release, columns cycle 1110,1101,1011,0111,1110 with 4 cycles each.
- Press "5" (row1,col1) held for 200 cycles -> exactly one key_valid with key_code=5, digit_valid with digit_val=5, op_val stays 00. Press "0" -> digit_val=0, key_code=13.
- Press "+" (row0,col3), then "-" (row1,col3) -> op_val=01 for exactly one cycle, later op_val=10 for exactly one cycle, 00 otherwise. Press "=" -> eq_pulse once. Press C -> clr_pulse once.
- Bounce on "7": toggle row2 every 3 cycles for 30 cycles, then hold low -> no pulse during the bounce, then exactly one digit_val=7. Release with 4-cycle glitches -> no second event; the next press of "7" after a clean release yields a second event.
- Multi-key in one column: "1" and "4" both held (pat=1100 on col0) -> no pulses. After full release, a single "4" -> digit_val=4.
- Unmapped key (row3,col0): held, then released -> no pulses of any kind, and scanning resumes with col_n=1101 after the release debounce.
